// File: rtl/core_pkg.sv
// Shared core types for the load/store unit: operator codes, LSU FSM states,
// byte-enable constants and helpers for alignment, lane selection and store replication.
package core_pkg;

    typedef enum logic [2:0] {LW, LH, LB, LHU, LBU, SW, SH, SB} load_store_func_code;

    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT} lsu_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_store(input load_store_func_code op);
        return op inside {SW, SH, SB};
    endfunction

    function automatic logic is_misaligned(input load_store_func_code op, input logic [1:0] off);
        case (op)
            LW, SW:      return off != 2'b00;
            LH, LHU, SH: return off[0];
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input load_store_func_code op, input logic [1:0] off);
        case (op)
            LB, LBU, SB: return BE_BYTE << off;
            LH, LHU, SH: return BE_HALF << {off[1], 1'b0};
            default:     return BE_WORD;
        endcase
    endfunction

    // Stores replicate the datum into every lane; the byte enables pick the live one.
    function automatic logic [31:0] store_lanes(input load_store_func_code op, input logic [31:0] wdata);
        case (op)
            SB:      return {4{wdata[7:0]}};
            SH:      return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/grant/rvalid data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;

    logic        data_req_op;
    logic        data_gnt_ip;
    logic [31:0] data_addr_op;
    logic        data_we_op;
    logic [3:0]  data_be_op;
    logic [31:0] data_wdata_op;
    logic        data_rvalid_ip;
    logic [31:0] data_rdata_ip;

    modport master (
        output data_req_op, data_addr_op, data_we_op, data_be_op, data_wdata_op,
        input  data_gnt_ip, data_rvalid_ip, data_rdata_ip
    );

    modport slave (
        input  data_req_op, data_addr_op, data_we_op, data_be_op, data_wdata_op,
        output data_gnt_ip, data_rvalid_ip, data_rdata_ip
    );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// Combinational load alignment: shifts the raw word down by the byte offset and
// sign- or zero-extends according to the load operator. Shared with refill paths.
module lsu_load_extend
    import core_pkg::*;
(
    input  logic [31:0]         i_rdata,
    input  logic [1:0]          i_offset,
    input  load_store_func_code i_op,
    output logic [31:0]         o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        // NOTE: assign a default first so every path drives o_data and no latch is inferred.
        o_data = w_shifted;
        case (i_op)
            LB:      o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            LBU:     o_data = {24'd0, w_shifted[7:0]};
            LH:      o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            LHU:     o_data = {16'd0, w_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Execute-stage load/store unit: one transaction at a time on a req/gnt/rvalid bus.
// Define LSU_TIMEOUT_EN to build the bus watchdog (TIMEOUT_CYCLES) and bus_error_op.
module load_store_unit
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en_lsu_ip,
    input  load_store_func_code lsu_operator_ip,
    input  logic [31:0]         addr_ip,
    input  logic                addr_valid_ip,
    input  logic [31:0]         wdata_ip,
    load_store_unit_if.master   bus,
    output logic [31:0]         mem_data_op,
    output logic                mem_data_valid_op,
    output logic                store_done_op,
    output logic                misaligned_op,
    output logic                bus_error_op,
    output logic                lsu_busy_op
);

    lsu_state_e          r_state;
    load_store_func_code r_op;
    logic [1:0]          r_offset;
    logic                r_req;
    logic                r_we;
    logic [3:0]          r_be;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_mem_data;
    logic                r_mem_valid;
    logic                r_store_done;
    logic                r_misaligned;

    logic                w_accept;
    logic                w_abort;
    logic [31:0]         w_load_data;

    assign w_accept = (r_state == LSU_IDLE) && en_lsu_ip && addr_valid_ip;

    lsu_load_extend u_load_extend (
        .i_rdata  (bus.data_rdata_ip),
        .i_offset (r_offset),
        .i_op     (r_op),
        .o_data   (w_load_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_error;
    logic             w_progress;

    // A grant or response arriving on the expiry cycle still wins over the abort.
    assign w_progress = ((r_state == LSU_REQ)  && bus.data_gnt_ip) ||
                        ((r_state == LSU_WAIT) && bus.data_rvalid_ip);
    assign w_abort    = (r_state != LSU_IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES)) && !w_progress;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_bus_error <= w_abort;
            if ((r_state == LSU_IDLE) || w_progress || w_abort) r_cnt <= '0;
            else                                                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus_error_op = r_bus_error;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_abort          = 1'b0;
    assign bus_error_op     = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= LSU_IDLE;
            r_op         <= LW;
            r_offset     <= '0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_data   <= '0;
            r_mem_valid  <= 1'b0;
            r_store_done <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_mem_valid  <= 1'b0;
            r_store_done <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                LSU_IDLE: begin
                    if (w_accept) begin
                        if (is_misaligned(lsu_operator_ip, addr_ip[1:0])) begin
                            r_misaligned <= 1'b1;
                        end else begin
                            r_state  <= LSU_REQ;
                            r_req    <= 1'b1;
                            r_op     <= lsu_operator_ip;
                            r_offset <= addr_ip[1:0];
                            r_addr   <= {addr_ip[31:2], 2'b00};
                            r_we     <= is_store(lsu_operator_ip);
                            r_be     <= byte_enable(lsu_operator_ip, addr_ip[1:0]);
                            r_wdata  <= store_lanes(lsu_operator_ip, wdata_ip);
                        end
                    end
                end
                LSU_REQ: begin
                    if (bus.data_gnt_ip) begin
                        r_state <= LSU_WAIT;
                        r_req   <= 1'b0;
                    end else if (w_abort) begin
                        r_state <= LSU_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                LSU_WAIT: begin
                    if (bus.data_rvalid_ip) begin
                        r_state <= LSU_IDLE;
                        if (r_we) begin
                            r_store_done <= 1'b1;
                        end else begin
                            r_mem_data  <= w_load_data;
                            r_mem_valid <= 1'b1;
                        end
                    end else if (w_abort) begin
                        r_state <= LSU_IDLE;
                    end
                end
                default: begin
                    r_state <= LSU_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_req_op   = r_req;
    assign bus.data_addr_op  = r_addr;
    assign bus.data_we_op    = r_we;
    assign bus.data_be_op    = r_be;
    assign bus.data_wdata_op = r_wdata;

    assign mem_data_op       = r_mem_data;
    assign mem_data_valid_op = r_mem_valid;
    assign store_done_op     = r_store_done;
    assign misaligned_op     = r_misaligned;
    assign lsu_busy_op       = (r_state != LSU_IDLE);

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Execute-stage load/store unit that sits directly downstream of instruction decode. It takes the decoded LSU enable and operator, the ALU-computed effective address and the store data, and runs one transaction at a time on a request/grant/rvalid data-memory bus. It returns sign- or zero-extended load data, with a valid pulse, to the register-file writeback mux. While a transaction is outstanding it raises a busy flag so the core can stall.

## Interface
- TIMEOUT_CYCLES, 16: bus watchdog limit in cycles; used only with LSU_TIMEOUT_EN.
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en_lsu_ip  in  1  decoded LSU enable.
- lsu_operator_ip  in  load_store_func_code  one of LW, LH, LB, LHU, LBU, SW, SH, SB.
- addr_ip  in  32  effective address (ALU result).
- addr_valid_ip  in  1  addr_ip valid (ALU result valid).
- wdata_ip  in  32  store data (register rs2).
- data_req_op  out  1  bus request.
- data_gnt_ip  in  1  bus grant.
- data_addr_op  out  32  word address; bits [1:0] always 0.
- data_we_op  out  1  1 = store, 0 = load.
- data_be_op  out  4  byte enables.
- data_wdata_op  out  32  lane-aligned store data.
- data_rvalid_ip  in  1  response valid; for loads, the data is on data_rdata_ip.
- data_rdata_ip  in  32  raw read word.
- mem_data_op  out  32  extended load result.
- mem_data_valid_op  out  1  one-cycle pulse qualifying mem_data_op.
- store_done_op  out  1  one-cycle pulse when a store completes.
- misaligned_op  out  1  one-cycle pulse when an access is rejected as misaligned.
- bus_error_op  out  1  one-cycle pulse when the watchdog fires; tied 0 without LSU_TIMEOUT_EN.
- lsu_busy_op  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - A request is accepted when en_lsu_ip & addr_valid_ip.
  - In every other state, input requests are ignored.
- Misaligned accesses:
  - Defined as LW/SW with addr[1:0] != 0, or LH/LHU/SH with addr[0] = 1.
  - Response: misaligned_op pulses, there is no bus activity, and the FSM stays in IDLE.
- Aligned accesses:
  - On acceptance, latch op and addr[1:0], then go to REQ.
  - Byte enables:
    - SB/LB/LBU: 0001 << addr[1:0].
    - SH/LH/LHU: 0011 << {addr[1],1'b0}.
    - SW/LW: 1111.
  - Store data lanes:
    - SB: {4{wdata[7:0]}}.
    - SH: {2{wdata[15:0]}}.
    - SW: wdata as is.
- REQ:
  - data_req_op = 1; addr, we, be and wdata are held stable.
  - On data_gnt_ip, go to WAIT (data_req_op deasserts the next cycle).
- WAIT:
  - On data_rvalid_ip, return to IDLE.
  - Loads: shift rdata right by 8*offset. LB sign-extends from bit 7, LBU zero-extends from bit 7, LH sign-extends from bit 15, LHU zero-extends from bit 15, LW passes through. Register the result into mem_data_op and pulse mem_data_valid_op.
  - Stores: pulse store_done_op.
- rvalid while in IDLE or REQ is ignored.
- mem_data_op holds its last value between pulses.

## Timing
- Reset value of every output is 0, including mem_data_op.
- Asserting reset mid-transaction drops data_req_op immediately and returns the FSM to IDLE. No completion pulse is produced.
- Accept in cycle T (IDLE) -> data_req_op high in T+1.
- Grant in cycle G -> WAIT from G+1; rvalid is legal from G+1 onward.
- rvalid in cycle R -> result pulse (mem_data_valid_op or store_done_op) in R+1, with the FSM already in IDLE.
- A new request is accepted in R+1, the same cycle as the pulse.
- Minimum load latency with a zero-wait bus: T -> mem_data_valid_op at T+3.
- misaligned_op pulses at T+1.
- lsu_busy_op is high from T+1 through R inclusive and is decoded from the state register only.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A cycle counter runs in REQ and WAIT and clears on every state change.
  - When the counter reaches TIMEOUT_CYCLES, the FSM aborts to IDLE, data_req_op drops, and bus_error_op pulses the next cycle.
  - No completion pulse is produced for the aborted transaction.
- LSU_TIMEOUT_EN undefined:
  - No counter is built; the FSM waits indefinitely.
  - bus_error_op is constant 0.

## Structure
- CORE_PKG holds:
  - load_store_func_code (existing).
  - New lsu_state_e {LSU_IDLE, LSU_REQ, LSU_WAIT}.
  - Byte-enable constants BE_BYTE = 4'b0001, BE_HALF = 4'b0011, BE_WORD = 4'b1111.
- Sub-module lsu_load_extend: combinational. Inputs are raw word, byte offset and op; output is the extended 32-bit result. It is reused by any future cache-refill path.

## Test plan
- LW from addr 0x100, zero-wait bus returning rdata 0xDEADBEEF:
  - data_addr_op = 0x100, be = 1111.
  - mem_data_op = 0xDEADBEEF, with mem_data_valid_op at T+3.
- LB and LBU at addr 0x103 with rdata 0x80112233:
  - be = 1000.
  - LB returns 0xFFFFFF80; LBU returns 0x00000080.
- SH at addr 0x202 with wdata 0x0000ABCD, grant delayed 3 cycles:
  - be = 1100, data_wdata_op = 0xABCDABCD, held stable throughout REQ.
  - store_done_op pulses once.
- LW at addr 0x101: misaligned_op pulses at T+1, data_req_op stays 0, lsu_busy_op stays 0.
- Reset asserted while in WAIT:
  - Outputs go to 0 asynchronously and the FSM is in IDLE.
  - A late rvalid arriving after reset produces no pulse.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 16, grant never arrives:
  - The FSM aborts to IDLE and bus_error_op pulses once.
  - A following LW completes normally.
